// File: rtl/counter_pkg.sv
// Shared types and constants for the counter sequencer and its datapath.
// Holds the command op encoding, the FSM states and the default counter width.
package counter_pkg;

   localparam int WIDTH_DEFAULT = 4;

   typedef enum logic [1:0] {
      OP_UP     = 2'd0,
      OP_DOWN   = 2'd1,
      OP_BOUNCE = 2'd2,
      OP_RSVD   = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/updown_counter.sv
// Loadable up/down counter used as the sequencer datapath.
// A load takes priority over a step; with neither, the value is held.
module updown_counter
   import counter_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             dir,
   output logic [WIDTH-1:0] s
);

   localparam logic [WIDTH-1:0] One = WIDTH'(1);

   logic [WIDTH-1:0] s_q;
   logic [WIDTH-1:0] s_d;

   always_comb begin
      s_d = s_q;
      if (load) begin
         s_d = load_val;
      end else if (en) begin
         s_d = dir ? (s_q - One) : (s_q + One);
      end
   end

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         s_q <= '0;
      end else begin
         s_q <= s_d;
      end
   end

   assign s = s_q;

endmodule

// File: rtl/counter_sequencer.sv
// Command-driven counter sequencer: runs UP, DOWN or BOUNCE sweeps between latched
// limits for a number of passes (0 = until abort), then pulses done for one cycle.
module counter_sequencer
   import counter_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_lo,
   input  logic [WIDTH-1:0] cmd_hi,
   input  logic [3:0]       cmd_passes,
   input  logic             abort,
   output logic [WIDTH-1:0] s,
   output logic             dir,
   output logic             busy,
   output logic             done,
   output logic             err
);

   state_e           state_q;
   op_e              op_q;
   logic [WIDTH-1:0] lo_q;
   logic [WIDTH-1:0] hi_q;
   logic [3:0]       passCnt_q;
   logic             dir_q;
   logic             dir_d;
   logic             err_q;

   logic             cmdBad;
   logic             passEnd;
   logic             lastPass;
   logic             cntLoad;
   logic [WIDTH-1:0] cntLoadVal;
   logic             cntEn;
   logic [WIDTH-1:0] sVal;

   assign cmdBad = (cmd_lo > cmd_hi) || (op_e'(cmd_op) == OP_RSVD);

   // A BOUNCE pass ends only on the return to lo, i.e. while already heading down.
   always_comb begin
      passEnd = 1'b0;
      unique case (op_q)
         OP_UP:     passEnd = (sVal == hi_q);
         OP_DOWN:   passEnd = (sVal == lo_q);
         OP_BOUNCE: passEnd = (lo_q == hi_q) || (dir_q && (sVal == lo_q));
         default:   passEnd = 1'b0;
      endcase
   end

   assign lastPass = passEnd && (passCnt_q == 4'd1);

   always_comb begin
      cntLoad    = 1'b0;
      cntLoadVal = sVal;
      cntEn      = 1'b0;
      dir_d      = dir_q;
      unique case (state_q)
         ST_IDLE: begin
            if (cmd_valid && !cmdBad) begin
               cntLoad    = 1'b1;
               cntLoadVal = (op_e'(cmd_op) == OP_DOWN) ? cmd_hi : cmd_lo;
               dir_d      = (op_e'(cmd_op) == OP_DOWN);
            end
         end
         ST_RUN: begin
            if (!abort && !lastPass) begin
               unique case (op_q)
                  OP_UP: begin
                     if (passEnd) begin
                        cntLoad    = 1'b1;
                        cntLoadVal = lo_q;
                     end else begin
                        cntEn = 1'b1;
                     end
                  end
                  OP_DOWN: begin
                     if (passEnd) begin
                        cntLoad    = 1'b1;
                        cntLoadVal = hi_q;
                     end else begin
                        cntEn = 1'b1;
                     end
                  end
                  OP_BOUNCE: begin
                     // The turn and the first step away from the limit share one edge.
                     if (lo_q != hi_q) begin
                        cntEn = 1'b1;
                        if (!dir_q && (sVal == hi_q)) begin
                           dir_d = 1'b1;
                        end else if (dir_q && (sVal == lo_q)) begin
                           dir_d = 1'b0;
                        end
                     end
                  end
                  default: begin
                     cntEn = 1'b0;
                  end
               endcase
            end
         end
         default: begin
            cntEn = 1'b0;
         end
      endcase
   end

   updown_counter #(
      .WIDTH(WIDTH)
   ) uCounter (
      .clock   (clock),
      .clear   (clear),
      .load    (cntLoad),
      .load_val(cntLoadVal),
      .en      (cntEn),
      .dir     (dir_d),
      .s       (sVal)
   );

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state_q   <= ST_IDLE;
         op_q      <= OP_UP;
         lo_q      <= '0;
         hi_q      <= '0;
         passCnt_q <= 4'd0;
         dir_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         err_q <= 1'b0;
         dir_q <= dir_d;
         unique case (state_q)
            ST_IDLE: begin
               if (cmd_valid) begin
                  if (cmdBad) begin
                     err_q <= 1'b1;
                  end else begin
                     op_q      <= op_e'(cmd_op);
                     lo_q      <= cmd_lo;
                     hi_q      <= cmd_hi;
                     passCnt_q <= cmd_passes;
                     state_q   <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               // A zero pass count never decrements, so only abort can end it.
               if (abort) begin
                  state_q <= ST_DONE;
               end else if (passEnd && (passCnt_q != 4'd0)) begin
                  passCnt_q <= passCnt_q - 4'd1;
                  if (passCnt_q == 4'd1) begin
                     state_q <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign cmd_ready = (state_q == ST_IDLE);
   assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
   assign done      = (state_q == ST_DONE);
   assign err       = err_q;
   assign dir       = dir_q;
   assign s         = sVal;

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench for counter_sequencer: directed scenarios plus random commands,
// compared against a trajectory model built from the sweep rules.
module tb_counter_sequencer;

   localparam int WIDTH = 4;

   logic             clock;
   logic             clear;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [WIDTH-1:0] cmd_lo;
   logic [WIDTH-1:0] cmd_hi;
   logic [3:0]       cmd_passes;
   logic             abort;
   logic [WIDTH-1:0] s;
   logic             dir;
   logic             busy;
   logic             done;
   logic             err;

   int checkCount;
   int errorCount;
   int modelS;
   int expS[$];
   int expD[$];

   counter_sequencer #(
      .WIDTH(WIDTH)
   ) dut (
      .clock     (clock),
      .clear     (clear),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_lo    (cmd_lo),
      .cmd_hi    (cmd_hi),
      .cmd_passes(cmd_passes),
      .abort     (abort),
      .s         (s),
      .dir       (dir),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checkCount++;
      if (observed != expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Expected s and dir for every RUN cycle, one entry per cycle, np passes.
   function automatic void buildTraj(input int op, input int lo, input int hi, input int np);
      expS.delete();
      expD.delete();
      if (lo == hi) begin
         for (int p = 0; p < np; p++) begin
            expS.push_back(lo);
            expD.push_back(op == 1 ? 1 : 0);
         end
      end else if (op == 0) begin
         for (int p = 0; p < np; p++)
            for (int v = lo; v <= hi; v++) begin
               expS.push_back(v);
               expD.push_back(0);
            end
      end else if (op == 1) begin
         for (int p = 0; p < np; p++)
            for (int v = hi; v >= lo; v--) begin
               expS.push_back(v);
               expD.push_back(1);
            end
      end else begin
         expS.push_back(lo);
         expD.push_back(0);
         for (int p = 0; p < np; p++) begin
            for (int v = lo + 1; v <= hi; v++) begin
               expS.push_back(v);
               expD.push_back(0);
            end
            for (int v = hi - 1; v >= lo; v--) begin
               expS.push_back(v);
               expD.push_back(1);
            end
         end
      end
   endfunction

   task automatic applyStimulus(input int op, input int lo, input int hi, input int passes,
                                input bit doAbort, input int abortSeed);
      int n;
      int abortAt;
      int last;
      buildTraj(op, lo, hi, (passes == 0) ? 15 : passes);
      n       = expS.size();
      abortAt = (doAbort || passes == 0) ? (abortSeed % n) : -1;
      last    = 0;
      @(negedge clock);
      checkOutput("pre_ready", cmd_ready, 1);
      cmd_valid  = 1'b1;
      cmd_op     = 2'(op);
      cmd_lo     = WIDTH'(lo);
      cmd_hi     = WIDTH'(hi);
      cmd_passes = 4'(passes);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         cmd_valid = 1'b0;
         checkOutput("run_s", s, expS[i]);
         checkOutput("run_dir", dir, expD[i]);
         checkOutput("run_busy", busy, 1);
         checkOutput("run_done", done, 0);
         last = i;
         if (i == abortAt) begin
            abort = 1'b1;
            break;
         end
      end
      @(negedge clock);
      abort = 1'b0;
      checkOutput("done_pulse", done, 1);
      checkOutput("done_s", s, expS[last]);
      checkOutput("done_ready", cmd_ready, 0);
      @(negedge clock);
      checkOutput("end_done", done, 0);
      checkOutput("end_ready", cmd_ready, 1);
      checkOutput("end_busy", busy, 0);
      checkOutput("end_s", s, expS[last]);
      modelS = expS[last];
   endtask

   task automatic rejectCmd(input int op, input int lo, input int hi);
      @(negedge clock);
      cmd_valid  = 1'b1;
      cmd_op     = 2'(op);
      cmd_lo     = WIDTH'(lo);
      cmd_hi     = WIDTH'(hi);
      cmd_passes = 4'd1;
      @(negedge clock);
      cmd_valid = 1'b0;
      checkOutput("rej_err", err, 1);
      checkOutput("rej_ready", cmd_ready, 1);
      checkOutput("rej_busy", busy, 0);
      checkOutput("rej_s", s, modelS);
      @(negedge clock);
      checkOutput("rej_err_clr", err, 0);
   endtask

   initial begin
      int op;
      int lo;
      int hi;
      checkCount = 0;
      errorCount = 0;
      modelS     = 0;
      clear      = 1'b1;
      cmd_valid  = 1'b0;
      cmd_op     = 2'd0;
      cmd_lo     = '0;
      cmd_hi     = '0;
      cmd_passes = 4'd0;
      abort      = 1'b0;

      @(negedge clock);
      checkOutput("rst_s", s, 0);
      checkOutput("rst_dir", dir, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_err", err, 0);
      checkOutput("rst_ready", cmd_ready, 1);
      clear = 1'b0;

      applyStimulus(0, 2, 5, 1, 1'b0, 0);
      applyStimulus(2, 0, 15, 2, 1'b0, 0);
      applyStimulus(1, 3, 6, 2, 1'b0, 0);
      rejectCmd(0, 9, 4);
      rejectCmd(3, 1, 8);
      applyStimulus(0, 0, 15, 0, 1'b1, 7);

      // Abort while idle must leave everything untouched.
      @(negedge clock);
      abort = 1'b1;
      @(negedge clock);
      abort = 1'b0;
      checkOutput("idle_abort_busy", busy, 0);
      checkOutput("idle_abort_ready", cmd_ready, 1);
      checkOutput("idle_abort_done", done, 0);
      checkOutput("idle_abort_s", s, modelS);

      applyStimulus(2, 6, 6, 3, 1'b0, 0);
      applyStimulus(1, 4, 4, 2, 1'b0, 0);

      // Clear mid-BOUNCE at s=9 acts without a clock edge and suppresses done.
      @(negedge clock);
      cmd_valid  = 1'b1;
      cmd_op     = 2'd2;
      cmd_lo     = 4'd0;
      cmd_hi     = 4'd15;
      cmd_passes = 4'd2;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         cmd_valid = 1'b0;
      end
      checkOutput("pre_clear_s", s, 9);
      clear = 1'b1;
      #1;
      checkOutput("clear_s", s, 0);
      checkOutput("clear_busy", busy, 0);
      checkOutput("clear_ready", cmd_ready, 1);
      checkOutput("clear_dir", dir, 0);
      @(negedge clock);
      checkOutput("clear_no_done", done, 0);
      clear  = 1'b0;
      modelS = 0;
      applyStimulus(0, 1, 3, 1, 1'b0, 0);

      for (int k = 0; k < 30; k++) begin
         op = int'($urandom_range(0, 3));
         lo = int'($urandom_range(0, 15));
         hi = int'($urandom_range(0, 15));
         if (op == 3 || lo > hi) begin
            rejectCmd(op, lo, hi);
         end else begin
            applyStimulus(op, lo, hi, int'($urandom_range(0, 3)),
                          ($urandom_range(0, 3) == 0), int'($urandom_range(0, 1000)));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
